// File: rtl/syndrome_pkg.sv
// -----------------------------------------------------------------------------
// syndrome_pkg
// Shared definitions for the repetition-code syndrome generator:
//   - syn_state_e : round-sequencing FSM states
//   - num_anc()   : ancilla count derived from the data-qubit count
// -----------------------------------------------------------------------------
package syndrome_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEASURE   = 2'd1,
    PRESENT   = 2'd2,
    WAIT_CORR = 2'd3
  } syn_state_e;

  // A 1-D chain of n data qubits has n-1 nearest-neighbour checks.
  function automatic int num_anc(input int num_data);
    return num_data - 1;
  endfunction

endpackage

// File: rtl/syndrome_parity.sv
// -----------------------------------------------------------------------------
// syndrome_parity
// Purely combinational nearest-neighbour parity of a repetition-code frame.
// Ports:
//   frame [NUM_DATA-1:0] in  : current error frame
//   syn   [NUM_ANC-1:0]  out : syn[i] = frame[i] ^ frame[i+1]
// -----------------------------------------------------------------------------
module syndrome_parity
  import syndrome_pkg::*;
#(
  parameter int NUM_DATA = 8,
  localparam int NUM_ANC = num_anc(NUM_DATA)
) (
  input  logic [NUM_DATA-1:0] frame,
  output logic [NUM_ANC-1:0]  syn
);

  function automatic logic [NUM_ANC-1:0] chain_parity(input logic [NUM_DATA-1:0] f);
    logic [NUM_ANC-1:0] p;
    p = {NUM_ANC{1'b0}};
    for (int i = 0; i < NUM_ANC; i++) begin
      p[i] = f[i] ^ f[i+1];
    end
    return p;
  endfunction

  // Parity of adjacent data-qubit pairs.
  always_comb begin
    syn = chain_parity(frame);
  end

endmodule

// File: rtl/repetition_syndrome_gen.sv
// -----------------------------------------------------------------------------
// repetition_syndrome_gen
// Holds the error frame of a 1-D repetition chain, injects errors each round,
// presents the parity syndrome to the decoder over valid/ready, applies the
// returned correction and flags the residual outcome.
// Optional macro: DIFF_SYNDROME_EN -- output detection events (syndrome XOR
// previous round's syndrome) instead of raw parity.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   round_start,err_mask: start a round / errors to inject (IDLE only)
//   syn_valid,syn_ready : syndrome handshake, syndrome[NUM_ANC-1:0]
//   corr_ready,corr_valid,corr_mask : correction handshake (WAIT_CORR only)
//   round_id            : completed-round counter (wraps)
//   busy                : FSM not idle
//   residual_ok         : frame all-zero after last correction
//   logical_err         : frame all-ones after last correction
// All outputs are registered.
// -----------------------------------------------------------------------------
module repetition_syndrome_gen
  import syndrome_pkg::*;
#(
  parameter int NUM_DATA = 8,
  parameter int ROUND_W  = 8,
  localparam int NUM_ANC = num_anc(NUM_DATA)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                round_start,
  input  logic [NUM_DATA-1:0] err_mask,
  output logic                syn_valid,
  input  logic                syn_ready,
  output logic [NUM_ANC-1:0]  syndrome,
  output logic                corr_ready,
  input  logic                corr_valid,
  input  logic [NUM_DATA-1:0] corr_mask,
  output logic [ROUND_W-1:0]  round_id,
  output logic                busy,
  output logic                residual_ok,
  output logic                logical_err
);

  syn_state_e          state;
  syn_state_e          next_state;
  logic [NUM_DATA-1:0] frame;
  logic [NUM_DATA-1:0] corrected;
  logic [NUM_ANC-1:0]  parity;

  syndrome_parity #(.NUM_DATA(NUM_DATA)) u_parity (
    .frame (frame),
    .syn   (parity)
  );

  // Next-state logic and the frame as it would look after this correction.
  always_comb begin
    next_state = state;
    corrected  = frame ^ corr_mask;
    case (state)
      IDLE: begin
        if (round_start) next_state = MEASURE;
        else             next_state = IDLE;
      end
      MEASURE: next_state = PRESENT;
      PRESENT: begin
        if (syn_ready) next_state = WAIT_CORR;
        else           next_state = PRESENT;
      end
      WAIT_CORR: begin
        if (corr_valid) next_state = IDLE;
        else            next_state = WAIT_CORR;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; handshake/status flags are registered from next_state so
  // they always agree with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      syn_valid  <= 1'b0;
      corr_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      syn_valid  <= (next_state == PRESENT);
      corr_ready <= (next_state == WAIT_CORR);
      busy       <= (next_state != IDLE);
    end
  end

`ifdef DIFF_SYNDROME_EN
  logic [NUM_ANC-1:0] prev_syn;

  // Detection events: this round's parity against the previous round's.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_syn <= {NUM_ANC{1'b0}};
      syndrome <= {NUM_ANC{1'b0}};
    end else if (state == MEASURE) begin
      prev_syn <= parity;
      syndrome <= parity ^ prev_syn;
    end
  end
`else
  // Raw parity captured once per round; held through backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syndrome <= {NUM_ANC{1'b0}};
    end else if (state == MEASURE) begin
      syndrome <= parity;
    end
  end
`endif

  // Frame, round counter and residual flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame       <= {NUM_DATA{1'b0}};
      round_id    <= {ROUND_W{1'b0}};
      residual_ok <= 1'b1;
      logical_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (round_start) frame <= frame ^ err_mask;
        end
        WAIT_CORR: begin
          if (corr_valid) begin
            frame       <= corrected;
            residual_ok <= (corrected == {NUM_DATA{1'b0}});
            logical_err <= &corrected;
            round_id    <= round_id + {{(ROUND_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_repetition_syndrome_gen.sv
module tb_repetition_syndrome_gen;

  localparam int NUM_DATA = 8;
  localparam int NUM_ANC  = 7;
  localparam int ROUND_W  = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                round_start = 1'b0;
  logic [NUM_DATA-1:0] err_mask = '0;
  logic                syn_valid;
  logic                syn_ready = 1'b0;
  logic [NUM_ANC-1:0]  syndrome;
  logic                corr_ready;
  logic                corr_valid = 1'b0;
  logic [NUM_DATA-1:0] corr_mask = '0;
  logic [ROUND_W-1:0]  round_id;
  logic                busy;
  logic                residual_ok;
  logic                logical_err;

  repetition_syndrome_gen #(.NUM_DATA(NUM_DATA), .ROUND_W(ROUND_W)) dut (
    .clk(clk), .rst_n(rst_n), .round_start(round_start), .err_mask(err_mask),
    .syn_valid(syn_valid), .syn_ready(syn_ready), .syndrome(syndrome),
    .corr_ready(corr_ready), .corr_valid(corr_valid), .corr_mask(corr_mask),
    .round_id(round_id), .busy(busy), .residual_ok(residual_ok),
    .logical_err(logical_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [NUM_DATA-1:0] m_frame = '0;
  logic [NUM_ANC-1:0]  m_prev  = '0;
  logic [ROUND_W-1:0]  m_rid   = '0;

  // Scoreboards: expected syndromes, expected {residual_ok, logical_err}
  logic [NUM_ANC-1:0]  syn_q[$];
  logic [1:0]          res_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [NUM_ANC-1:0] ref_syn(input logic [NUM_DATA-1:0] f);
    logic [NUM_ANC-1:0] p;
    for (int i = 0; i < NUM_ANC; i++) p[i] = f[i] ^ f[i+1];
    return p;
  endfunction

  task automatic push_round(input logic [NUM_DATA-1:0] err);
    logic [NUM_ANC-1:0] p;
    m_frame = m_frame ^ err;
    p = ref_syn(m_frame);
`ifdef DIFF_SYNDROME_EN
    syn_q.push_back(p ^ m_prev);
    m_prev = p;
`else
    syn_q.push_back(p);
`endif
  endtask

  // One full round; bp = cycles of backpressure with ignored pulses in between.
  task automatic do_round(input logic [NUM_DATA-1:0] err, input logic [NUM_DATA-1:0] corr,
                          input int bp, input bit full);
    logic [NUM_ANC-1:0] exp_syn;
    logic [NUM_DATA-1:0] nf;
    logic [1:0] exp_res;
    @(negedge clk);
    round_start = 1'b1; err_mask = err; syn_ready = 1'b0;
    push_round(err);
    @(negedge clk);
    round_start = 1'b0; err_mask = '0;
    if (full) check_val("lat1_valid", syn_valid, 1'b0);
    @(negedge clk);
    check_val("lat2_valid", syn_valid, 1'b1);
    exp_syn = syn_q[0];
    if (full) check_val("syndrome_first", syndrome, exp_syn);
    for (int i = 0; i < bp; i++) begin
      round_start = 1'b1; err_mask = 8'hFF;
      corr_valid = 1'b1;  corr_mask = 8'hFF;
      @(negedge clk);
      check_val("bp_valid", syn_valid, 1'b1);
      check_val("bp_syndrome", syndrome, exp_syn);
    end
    round_start = 1'b0; err_mask = '0;
    // handshake with a simultaneous (ignored) corr_valid
    syn_ready = 1'b1; corr_valid = 1'b1; corr_mask = 8'hFF;
    check_val("syndrome", syndrome, syn_q.pop_front());
    @(negedge clk);
    syn_ready = 1'b0; corr_valid = 1'b0; corr_mask = '0;
    if (full) begin
      check_val("hs_valid_drop", syn_valid, 1'b0);
      check_val("corr_ready", corr_ready, 1'b1);
    end
    corr_valid = 1'b1; corr_mask = corr;
    nf = m_frame ^ corr;
    m_frame = nf;
    m_rid = m_rid + 8'd1;
    exp_res = {(nf == 8'h00), (nf == 8'hFF)};
    res_q.push_back(exp_res);
    @(negedge clk);
    corr_valid = 1'b0; corr_mask = '0;
    exp_res = res_q.pop_front();
    check_val("residual_ok", residual_ok, exp_res[1]);
    check_val("logical_err", logical_err, exp_res[0]);
    check_val("round_id", round_id, m_rid);
    if (full) begin
      check_val("busy_idle", busy, 1'b0);
      check_val("corr_ready_idle", corr_ready, 1'b0);
    end
  endtask

  initial begin
    // Reset state
    #12;
    check_val("rst_valid", syn_valid, 1'b0);
    check_val("rst_corr_ready", corr_ready, 1'b0);
    check_val("rst_round_id", round_id, 8'd0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_residual_ok", residual_ok, 1'b1);
    check_val("rst_logical_err", logical_err, 1'b0);
    check_val("rst_syndrome", syndrome, 7'd0);
    @(negedge clk); rst_n = 1'b1;

    // Single error, corrected
    do_round(8'h04, 8'h04, 0, 1'b1);
    // Backpressure with ignored pulses
    do_round(8'h04, 8'h04, 5, 1'b1);
    // Logical error, then a quiet round on the flipped chain
    do_round(8'h0F, 8'hF0, 0, 1'b1);
    do_round(8'h00, 8'hFF, 0, 1'b1);
    // Persistence across rounds
    do_round(8'h04, 8'h00, 0, 1'b1);
    do_round(8'h00, 8'h04, 0, 1'b1);

    // Async reset mid-PRESENT
    @(negedge clk);
    round_start = 1'b1; err_mask = 8'h81;
    @(negedge clk);
    round_start = 1'b0; err_mask = '0;
    @(negedge clk);
    check_val("pre_rst_valid", syn_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", syn_valid, 1'b0);
    check_val("arst_corr_ready", corr_ready, 1'b0);
    check_val("arst_round_id", round_id, 8'd0);
    check_val("arst_residual_ok", residual_ok, 1'b1);
    check_val("arst_busy", busy, 1'b0);
    m_frame = '0; m_prev = '0; m_rid = '0;
    syn_q.delete(); res_q.delete();
    @(negedge clk); rst_n = 1'b1;
    do_round(8'h04, 8'h04, 0, 1'b1);

    // Counter wrap: round_id 1 -> 255 -> 0
    for (int r = 0; r < 255; r++) begin
      do_round(8'h00, 8'h00, 0, (r >= 253));
    end
    check_val("wrap_round_id", round_id, 8'd0);
    check_val("wrap_residual_ok", residual_ok, 1'b1);
    check_val("wrap_logical_err", logical_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/repetition_syndrome_gen.md
Name: repetition_syndrome_gen

Overview:
Produces syndrome rounds for a 1-D repetition-code chain and consumes the decoder's corrections. It is the counterpart of the leaf/tree decode path.
- Holds an error frame over NUM_DATA data qubits and XORs in injected errors each round.
- Computes nearest-neighbour parity syndromes and hands them to the decoder over a valid/ready handshake.
- Applies the returned correction mask and flags the residual outcome (clean or logical error).
- Sits between the error-injection stimulus and the decoder tree in the emulation datapath.

Parameters:
NUM_DATA, 8, number of data qubits in the chain (minimum 2)
NUM_ANC, NUM_DATA-1, number of ancilla/syndrome bits (derived; not overridden)
ROUND_W, 8, width of the round counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
round_start  in  1  begin a round; sampled only in IDLE
err_mask  in  NUM_DATA  errors injected this round; sampled with round_start
syn_valid  out  1  syndrome available
syn_ready  in  1  decoder accepts syndrome
syndrome  out  NUM_ANC  syndrome[i] = frame[i] ^ frame[i+1]
corr_ready  out  1  high in WAIT_CORR only
corr_valid  in  1  correction mask valid
corr_mask  in  NUM_DATA  correction to XOR into the frame
round_id  out  ROUND_W  index of the current/last round
busy  out  1  state != IDLE
residual_ok  out  1  frame all-zero after the last correction
logical_err  out  1  frame all-ones after the last correction

Behaviour:
- Reset (async, rst_n=0): state=IDLE; frame=0; syndrome=0; syn_valid=0; corr_ready=0; round_id=0; busy=0; residual_ok=1; logical_err=0. Reset mid-round aborts the round with no partial commit.
- FSM states: IDLE, MEASURE, PRESENT, WAIT_CORR.
- IDLE: if round_start=1, then frame <= frame ^ err_mask and go to MEASURE. round_start in any other state is ignored, and err_mask is not applied.
- MEASURE (1 cycle): syndrome register <= parity(frame); go to PRESENT.
- Latency: syn_valid rises 2 cycles after round_start is sampled.
- PRESENT: syn_valid=1. syndrome is held stable until syn_ready=1, and syn_valid does not drop before the handshake. On the handshake, syn_valid <= 0 and the FSM goes to WAIT_CORR.
- WAIT_CORR: corr_ready=1. On corr_valid=1:
  - frame <= frame ^ corr_mask
  - residual_ok <= (frame^corr_mask)==0
  - logical_err <= &(frame^corr_mask)
  - round_id <= round_id+1 (wraps 2^ROUND_W-1 -> 0)
  - go to IDLE.
- corr_valid outside WAIT_CORR is ignored. This includes a corr_valid in the same cycle as the PRESENT handshake.
- The frame persists across rounds; only corrections and reset clear it. residual_ok and logical_err hold until the next correction.
- All outputs are registered. There is no combinational path from input to output.

Optional Feature:
- Macro: DIFF_SYNDROME_EN.
- Defined: the block keeps prev_syn (reset 0). In MEASURE, syndrome <= parity(frame) ^ prev_syn and prev_syn <= parity(frame), so the output is detection events.
- Undefined: raw parity syndrome; no prev_syn register.

Decomposition:
- Shared package syndrome_pkg holds:
  - state enum syn_state_e {IDLE, MEASURE, PRESENT, WAIT_CORR}
  - a localparam function deriving NUM_ANC from NUM_DATA
- One natural sub-module: syndrome_parity, combinational, frame in -> NUM_ANC parity bits out. It is reused by the decoder bench model.

Test Plan:
- Reset: assert rst_n=0 mid-PRESENT -> syn_valid=0, corr_ready=0, round_id=0, residual_ok=1 asynchronously; the next round starts from frame=0.
- Single error: err_mask=8'h04, syn_ready=1 -> syn_valid 2 cycles later, syndrome=7'b0000110. Then corr_mask=8'h04 -> residual_ok=1, logical_err=0, round_id=1.
- Backpressure: hold syn_ready=0 for 5 cycles -> syn_valid stays 1 and syndrome stays stable. Pulses of round_start/corr_valid in this window are ignored and the frame is unchanged.
- Logical error: err_mask=8'h0F, corr_mask=8'hF0 -> logical_err=1, residual_ok=0. The next round with err_mask=0 gives syndrome=0.
- Persistence/diff: err 8'h04, corr 0, then a second round with err 0.
  - Without DIFF_SYNDROME_EN: both rounds give syndrome 7'b0000110.
  - With DIFF_SYNDROME_EN: the second round gives syndrome 0.
- Counter wrap: run 256 rounds with ROUND_W=8 -> round_id goes 255 -> 0 with no glitch on the other outputs.
